load_store_unit: RTL

- Memory-stage front end: accepts one load/store request from execute, checks alignment and funct3, and drives the byte-addressed data memory port (addr, wdata, width, read_en, write_en).
- Consumes the memory's valM/mem_fault, sign- or zero-extends load data, and returns a result or fault to writeback over a valid/ready handshake.
- At most one transaction in flight; the unit is directly upstream of the data memory.

---
 rtl/load_store_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage front end; checks and issues one load/store at a time, extends load data, returns result/fault.
// Ports: clock/reset; req_* from execute (valid/ready); resp_* to writeback (valid/ready);
//        mem_* registered drive to the byte-addressed data memory, mem_valM/mem_fault sampled back.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [1:0]      resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_width,
  output logic            mem_read_en,
  output logic            mem_write_en,
  input  logic [XLEN-1:0] mem_valM,
  input  logic            mem_fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_next;
  logic [2:0] f3, n_f3;
  logic is_store, n_is_store;
  logic illegal, misaligned;
  logic [XLEN-1:0] store_data, ext;
  logic n_ready, n_valid, n_rd, n_wr;
  logic [XLEN-1:0] n_data, n_addr, n_wdata;
  logic [1:0] n_fault;
  logic [2:0] n_width;
  assign illegal = req_write ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign store_data = req_funct3[1:0] == 2'b00 ? {{(XLEN-8){1'b0}}, req_wdata[7:0]} :
                      req_funct3[1:0] == 2'b01 ? {{(XLEN-16){1'b0}}, req_wdata[15:0]} : req_wdata;
  // f3 was captured at accept; LW falls through to the raw word
  assign ext = f3 == 3'b000 ? {{(XLEN-8){mem_valM[7]}}, mem_valM[7:0]} :
               f3 == 3'b001 ? {{(XLEN-16){mem_valM[15]}}, mem_valM[15:0]} :
               f3 == 3'b100 ? {{(XLEN-8){1'b0}}, mem_valM[7:0]} :
               f3 == 3'b101 ? {{(XLEN-16){1'b0}}, mem_valM[15:0]} : mem_valM;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (illegal | misaligned) ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // enables default low so they are high only for the single ACCESS cycle
  always_comb begin
    n_ready = state_next == IDLE;
    n_valid = resp_valid;
    n_data = resp_data;
    n_fault = resp_fault;
    n_addr = mem_addr;
    n_wdata = mem_wdata;
    n_width = mem_width;
    n_rd = 1'b0;
    n_wr = 1'b0;
    n_f3 = f3;
    n_is_store = is_store;
    if (state == IDLE && req_valid) begin
      n_f3 = req_funct3;
      n_is_store = req_write;
      n_data = '0;
      n_valid = illegal | misaligned;
      n_fault = illegal ? 2'b11 : misaligned ? 2'b01 : 2'b00;
      if (!(illegal | misaligned)) begin
        n_addr = req_addr;
        n_wdata = store_data;
        n_width = {1'b0, req_funct3[1:0]};
        n_rd = !req_write;
        n_wr = req_write;
      end
    end else if (state == ACCESS) begin
      n_valid = 1'b1;
      n_fault = mem_fault ? 2'b10 : 2'b00;
      n_data = (mem_fault | is_store) ? '0 : ext;
    end else if (state == RESP && resp_ready) begin
      n_valid = 1'b0;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_fault <= 2'b00;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_width <= 3'd0;
      mem_read_en <= 1'b0;
      mem_write_en <= 1'b0;
      f3 <= 3'd0;
      is_store <= 1'b0;
    end else begin
      req_ready <= n_ready;
      resp_valid <= n_valid;
      resp_data <= n_data;
      resp_fault <= n_fault;
      mem_addr <= n_addr;
      mem_wdata <= n_wdata;
      mem_width <= n_width;
      mem_read_en <= n_rd;
      mem_write_en <= n_wr;
      f3 <= n_f3;
      is_store <= n_is_store;
    end
endmodule
